shift_sequencer: RTL and testbench
==================================

# shift_sequencer

Multi-cycle shift controller that time-shares one configurable power-of-two shift stage. It accepts a word, a shift amount and an operation, then applies stage 2^k once per cycle for each needed bit k of the amount, LSB first. It sits beside the EX-stage ALU as the low-area shift unit, with valid/ready handshakes on both sides.

## Interface
- DATA_W, 32, datapath width; must be a power of two.
- SHAMT_W, $clog2(DATA_W), shift-amount width; derived, not overridden.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request present.
- in_ready  out  1  sequencer can accept; high only in IDLE.
- in_data  in  DATA_W  operand.
- in_shamt  in  SHAMT_W  shift amount, 0..DATA_W-1.
- in_op  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROL.
- out_valid  out  1  result held in out_data.
- out_ready  in  1  consumer takes result.
- out_data  out  DATA_W  shifted result.
- busy  out  1  state is not IDLE.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: in_ready=1. On in_valid the sequencer latches data, shamt, op and sets k to the lowest needed stage.
  - If no stage is needed, the next state is DONE.
  - Otherwise the next state is SHIFT.
- SHIFT: each cycle, if stage k is needed, the register takes the stage-k output (shift by 2^k).
  - If k is the last needed stage, the next state is DONE.
  - Otherwise k advances to the next needed stage.
- DONE: out_valid=1. out_data is held stable while out_ready=0. On out_ready the next state is IDLE.
- A stage is "needed" when shamt[k]=1 with SHIFT_SKIP_ZERO_EN. Without the macro, every k=0..SHAMT_W-1 is visited and stages with shamt[k]=0 pass the data through.
- Fill rules per stage:
  - SLL: zeros into the LSBs.
  - SRL: zeros into the MSBs.
  - SRA: copies of the current bit DATA_W-1, which stays equal to the original sign.
  - ROL: bits leaving the MSB end re-enter at the LSB end.
- Result equals the single-cycle full barrel shift of in_data by in_shamt. Shift amounts are modulo DATA_W by construction.
- No new request is accepted in SHIFT or DONE. in_valid there is ignored and must be held by the requester.
- Reset (async, any state) forces:
  - state IDLE,
  - out_valid=0, busy=0, out_data=0,
  - internal k, shamt and op registers to 0.
- in_ready rises in the first cycle after rst_n deasserts.

## Timing
- Accept edge: the clock edge with in_valid & in_ready.
- N = popcount(in_shamt) with SHIFT_SKIP_ZERO_EN, else N = SHAMT_W (5 for 32-bit).
- out_valid is first high N+1 cycles after the accept edge, with a minimum of 1 for N=0. It then stays high until the edge where out_ready=1.
- in_ready is high again in the cycle after the out_ready handshake edge.
- Minimum issue interval: N+2 cycles.
- out_data is registered. No combinational path runs from in_* to out_*, or from out_ready to in_ready.

## Configuration
- SHIFT_SKIP_ZERO_EN defined: SHIFT visits only stages with shamt[k]=1, giving variable latency N=popcount(shamt).
- SHIFT_SKIP_ZERO_EN undefined: SHIFT always visits all SHAMT_W stages, giving fixed latency. This mode is used where deterministic issue timing is required.
- Results are identical in both modes.

## Structure
- Shared package shift_pkg holds:
  - op encodings SHOP_SLL, SHOP_SRL, SHOP_SRA, SHOP_ROL,
  - state encoding SEQ_IDLE/SEQ_SHIFT/SEQ_DONE,
  - the DATA_W default.
- Sub-module shift_stage: combinational, inputs data, stage index k, op; output is data shifted by 2^k with the op's fill rule.
- shift_sequencer holds the FSM, the k counter, the next-needed-stage priority logic and the result register.

## Test plan
- SLL 0x0000_0001 by 8: out_data=0x0000_0100. out_valid 2 cycles after accept with skip; 6 cycles without.
- SRA 0x8000_0000 by 31: out_data=0xFFFF_FFFF. N=5 in both modes.
- ROL 0x8000_0001 by 4: 0x0000_0018. SRL 0xF000_0000 by 28: 0x0000_000F.
- Shamt 0, SRL 0x1234_5678: out_data=0x1234_5678, out_valid 1 cycle after accept with skip.
- Backpressure: hold out_ready=0 for 10 cycles in DONE. out_data stays constant, in_ready stays 0, and a pending in_valid is not accepted until the cycle after out_ready=1.
- Assert rst_n low mid-SHIFT:
  - out_valid, busy and out_data go 0 immediately, without waiting for a clock edge.
  - After release, a fresh SLL 0x3 by 1 returns 0x6.

Source files
------------

// File: rtl/shift_pkg.sv
// ---------------------------------------------------------------------------
// shift_pkg
// Shared definitions for the multi-cycle shift sequencer and its shift stage.
//   - shop_e      : shift operation encodings (SLL, SRL, SRA, ROL)
//   - seq_state_e : sequencer FSM state encodings (IDLE, SHIFT, DONE)
//   - DATA_W_DEFAULT : default datapath width (must be a power of two)
// No ports; imported by shift_stage and shift_sequencer.
// ---------------------------------------------------------------------------
package shift_pkg;

  localparam int DATA_W_DEFAULT = 32;

  typedef enum logic [1:0] {
    SHOP_SLL = 2'b00,
    SHOP_SRL = 2'b01,
    SHOP_SRA = 2'b10,
    SHOP_ROL = 2'b11
  } shop_e;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'b00,
    SEQ_SHIFT = 2'b01,
    SEQ_DONE  = 2'b10
  } seq_state_e;

endpackage

// File: rtl/shift_stage.sv
// ---------------------------------------------------------------------------
// shift_stage
// Combinational power-of-two shift stage: shifts i_data by 2^i_k using the
// fill rule of i_op.
// Ports:
//   i_data [DATA_W-1:0]  operand
//   i_k    [SHAMT_W-1:0] stage index; shift distance is 2^i_k
//   i_op   shop_e        SLL / SRL / SRA / ROL
//   o_data [DATA_W-1:0]  shifted result
// ---------------------------------------------------------------------------
module shift_stage
  import shift_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEFAULT,
  parameter int SHAMT_W = $clog2(DATA_W)
) (
  input  logic [DATA_W-1:0]  i_data,
  input  logic [SHAMT_W-1:0] i_k,
  input  shop_e              i_op,
  output logic [DATA_W-1:0]  o_data
);

  // One extra bit so that DATA_W itself is representable for the rotate
  // complement; the largest stage distance is DATA_W/2.
  logic [SHAMT_W:0] w_amt;
  logic [SHAMT_W:0] w_rolBack;

  assign w_amt     = {{SHAMT_W{1'b0}}, 1'b1} << i_k;
  assign w_rolBack = (SHAMT_W + 1)'(DATA_W) - w_amt;

  always_comb begin
    o_data = i_data;
    unique case (i_op)
      SHOP_SLL: o_data = i_data << w_amt;
      SHOP_SRL: o_data = i_data >> w_amt;
      SHOP_SRA: o_data = $signed(i_data) >>> w_amt;
      SHOP_ROL: o_data = (i_data << w_amt) | (i_data >> w_rolBack);
      default:  o_data = i_data;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// ---------------------------------------------------------------------------
// shift_sequencer
// Low-area multi-cycle shifter: one shared shift_stage is applied once per
// cycle for each needed bit k of the shift amount, LSB first.
// Optional feature macro: SHIFT_SKIP_ZERO_EN
//   defined   - only stages with shamt[k]=1 are visited (latency popcount)
//   undefined - all SHAMT_W stages are visited (fixed latency)
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   request handshake (ready only in IDLE)
//   in_data, in_shamt     operand and shift amount
//   in_op                 00 SLL, 01 SRL, 10 SRA, 11 ROL
//   out_valid / out_ready result handshake (valid only in DONE)
//   out_data              registered result
//   busy                  FSM is not IDLE
// ---------------------------------------------------------------------------
module shift_sequencer
  import shift_pkg::*;
#(
  parameter  int DATA_W  = DATA_W_DEFAULT,
  localparam int SHAMT_W = $clog2(DATA_W)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic               busy
);

  seq_state_e         r_state;
  seq_state_e         w_nextState;
  logic [DATA_W-1:0]  r_data;
  logic [SHAMT_W-1:0] r_shamt;
  logic [SHAMT_W-1:0] r_k;
  shop_e              r_op;

  logic [DATA_W-1:0]  w_stageOut;
  logic [SHAMT_W-1:0] w_firstK;
  logic               w_firstNone;
  logic [SHAMT_W-1:0] w_nextK;
  logic               w_kIsLast;
  logic               w_accept;

  shift_stage #(
    .DATA_W (DATA_W),
    .SHAMT_W(SHAMT_W)
  ) u_stage (
    .i_data(r_data),
    .i_k   (r_k),
    .i_op  (r_op),
    .o_data(w_stageOut)
  );

`ifdef SHIFT_SKIP_ZERO_EN
  // Priority encoders: lowest set bit of the incoming amount, and the lowest
  // set bit of the latched amount strictly above the current stage. Scanning
  // downward lets the last hit win, which is the lowest qualifying index.
  always_comb begin
    w_firstK    = '0;
    w_firstNone = 1'b1;
    w_nextK     = r_k;
    w_kIsLast   = 1'b1;
    for (int i = SHAMT_W - 1; i >= 0; i--) begin
      if (in_shamt[i]) begin
        w_firstK    = SHAMT_W'(i);
        w_firstNone = 1'b0;
      end
      if (r_shamt[i] && (SHAMT_W'(i) > r_k)) begin
        w_nextK   = SHAMT_W'(i);
        w_kIsLast = 1'b0;
      end
    end
  end
`else
  // Every stage is visited in order; zero bits of the amount pass through.
  assign w_firstK    = '0;
  assign w_firstNone = 1'b0;
  assign w_nextK     = r_k + SHAMT_W'(1);
  assign w_kIsLast   = (r_k == SHAMT_W'(SHAMT_W - 1));
`endif

  assign w_accept = (r_state == SEQ_IDLE) && in_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SEQ_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Handshake outputs decode only the state register, so there is no
  // combinational path from in_* or out_ready to any output.
  always_comb begin
    w_nextState = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b1;
    unique case (r_state)
      SEQ_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          w_nextState = w_firstNone ? SEQ_DONE : SEQ_SHIFT;
        end
      end
      SEQ_SHIFT: begin
        if (w_kIsLast) begin
          w_nextState = SEQ_DONE;
        end
      end
      SEQ_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_nextState = SEQ_IDLE;
        end
      end
      default: begin
        w_nextState = SEQ_IDLE;
      end
    endcase
  end

  // The result register doubles as the working register; a stage whose
  // amount bit is clear leaves it untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_shamt <= '0;
      r_k     <= '0;
      r_op    <= SHOP_SLL;
    end else if (w_accept) begin
      r_data  <= in_data;
      r_shamt <= in_shamt;
      r_op    <= shop_e'(in_op);
      r_k     <= w_firstK;
    end else if (r_state == SEQ_SHIFT) begin
      if (r_shamt[r_k]) begin
        r_data <= w_stageOut;
      end
      if (!w_kIsLast) begin
        r_k <= w_nextK;
      end
    end
  end

  assign out_data = r_data;

endmodule

// File: tb/tb_shift_sequencer.sv
// ---------------------------------------------------------------------------
// tb_shift_sequencer
// Directed bench for shift_sequencer (32-bit). Expected results are
// hand-computed; expected latency follows SHIFT_SKIP_ZERO_EN.
// ---------------------------------------------------------------------------
module tb_shift_sequencer;
  import shift_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_shamt;
  logic [1:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        busy;

  int checkCount = 0;
  int failCount  = 0;

  shift_sequencer #(.DATA_W(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_shamt (in_shamt),
    .in_op    (in_op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Cycles from accept edge to first out_valid: stages visited plus one.
  function automatic int expLat(input logic [4:0] shamt);
`ifdef SHIFT_SKIP_ZERO_EN
    return $countones(shamt) + 1;
`else
    return (shamt == 5'd0) ? 6 : 6;
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; presents a request and returns at the falling
  // edge of the first cycle after the accept edge.
  task automatic applyStimulus(input string tag, input logic [1:0] op,
                               input logic [31:0] data, input logic [4:0] shamt);
    int waitCycles = 0;
    in_op    = op;
    in_data  = data;
    in_shamt = shamt;
    in_valid = 1'b1;
    while (!in_ready && waitCycles < 50) begin
      @(negedge clk);
      waitCycles++;
    end
    checkOutput({tag, " in_ready before accept"}, {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic waitResult(input string tag, input logic [31:0] expData, input int expLatency);
    int lat = 1;
    while (!out_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    checkOutput({tag, " latency"}, 32'(lat), 32'(expLatency));
    checkOutput({tag, " data"}, out_data, expData);
    checkOutput({tag, " in_ready in DONE"}, {31'b0, in_ready}, 32'd0);
  endtask

  task automatic releaseResult(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput({tag, " in_ready after release"}, {31'b0, in_ready}, 32'd1);
    checkOutput({tag, " out_valid after release"}, {31'b0, out_valid}, 32'd0);
  endtask

  task automatic runOp(input string tag, input logic [1:0] op, input logic [31:0] data,
                       input logic [4:0] shamt, input logic [31:0] expData);
    applyStimulus(tag, op, data, shamt);
    waitResult(tag, expData, expLat(shamt));
    releaseResult(tag);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_shamt  = '0;
    in_op     = '0;
    out_ready = 1'b0;
    #12;
    checkOutput("reset out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("reset busy", {31'b0, busy}, 32'd0);
    checkOutput("reset out_data", out_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post-reset in_ready", {31'b0, in_ready}, 32'd1);

    runOp("sll1by8",   SHOP_SLL, 32'h0000_0001, 5'd8,  32'h0000_0100);
    runOp("sra_min31", SHOP_SRA, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF);
    runOp("rol4",      SHOP_ROL, 32'h8000_0001, 5'd4,  32'h0000_0018);
    runOp("srl28",     SHOP_SRL, 32'hF000_0000, 5'd28, 32'h0000_000F);
    runOp("srl0",      SHOP_SRL, 32'h1234_5678, 5'd0,  32'h1234_5678);
    runOp("sra_pos4",  SHOP_SRA, 32'h7000_0000, 5'd4,  32'h0700_0000);
    runOp("rol8",      SHOP_ROL, 32'h1234_5678, 5'd8,  32'h3456_7812);
    runOp("sll31",     SHOP_SLL, 32'hFFFF_FFFF, 5'd31, 32'h8000_0000);
    runOp("sra1",      SHOP_SRA, 32'h8000_0000, 5'd1,  32'hC000_0000);
    runOp("rol31",     SHOP_ROL, 32'h0000_0003, 5'd31, 32'h8000_0001);

    // Backpressure with a pending request held on the input side.
    applyStimulus("bp", SHOP_SLL, 32'h0000_000A, 5'd3);
    waitResult("bp", 32'h0000_0050, expLat(5'd3));
    in_op    = SHOP_SLL;
    in_data  = 32'h0000_0001;
    in_shamt = 5'd1;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("bp hold data", out_data, 32'h0000_0050);
      checkOutput("bp hold in_ready", {31'b0, in_ready}, 32'd0);
      checkOutput("bp hold out_valid", {31'b0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("bp in_ready after handshake", {31'b0, in_ready}, 32'd1);
    checkOutput("bp pending not yet accepted", {31'b0, busy}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("bp pending accepted", {31'b0, busy}, 32'd1);
    waitResult("bp next", 32'h0000_0002, expLat(5'd1));
    releaseResult("bp next");

    // Asynchronous reset in the middle of SHIFT.
    applyStimulus("rst", SHOP_SRL, 32'hFFFF_FFFF, 5'd31);
    @(negedge clk);
    checkOutput("rst busy before reset", {31'b0, busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst async out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("rst async busy", {31'b0, busy}, 32'd0);
    checkOutput("rst async out_data", out_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst in_ready after release", {31'b0, in_ready}, 32'd1);
    runOp("rst sll3by1", SHOP_SLL, 32'h0000_0003, 5'd1, 32'h0000_0006);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
